// File: rtl/fetch_buffered.sv
// fetch_buffered: sequential-PC fetch with up to MAX_OUT pipelined icache requests feeding an in-order instruction queue.
// Latency: icache response -> valid_o one cycle later; redirect -> target request next cycle once no stale response is pending.
// Backpressure: decode stalls fill the queue; requests stop once queued + in-flight reaches DEPTH, so rsp_ready_o is always 1.
//
// Ports:
//   clk_i, rst_i                   clock, async active-high reset (the icache shares it)
//   redirect_i, redirect_pc_i      taken branch: load new PC, flush queue, drop in-flight responses
//   req_valid_o/req_ready_i/req_pc_o     icache request channel
//   rsp_valid_i/rsp_instr_i/rsp_ready_o  icache response channel (in request order)
//   valid_o/ready_i/pc_o/instr_o/id_o    queue head to decode

// Small circular FIFO with synchronous flush; used for the pc-tag FIFO and the instruction queue.
// Latency: head_o reflects a push on the following cycle.
// Backpressure: none internally; the caller must never push into a full FIFO without popping in the same cycle.
module fetch_buffered_fifo #(
  parameter int W  = 8,
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  dat_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  mem_q [N];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= nxt(wr_q);
      if (pop_i)  rd_q <= nxt(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage carries no reset; only pointers and count define what is valid.
  // When full with a simultaneous pop, the write lands in the slot being read out this cycle.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= dat_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

module fetch_buffered #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter int              ID_W     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_pc_o,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_instr_i,
  output logic            rsp_ready_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic [ID_W-1:0] id_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [ID_W-1:0] id;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [ID_W-1:0] id_q, id_d;

  logic [CW-1:0]   count;        // instruction queue occupancy
  logic [CW-1:0]   outstanding;  // non-stale requests in flight == pc-tag FIFO occupancy
  logic [XLEN-1:0] tag_pc;
  entry_t          enq_dat, head;

  logic req_fire, rsp_keep, rsp_drop, deq;

  // Requests are blocked while stale responses drain, so drop_cnt_q != 0 implies
  // outstanding == 0; a redirect can therefore fold outstanding into drop_cnt and
  // flush the tag FIFO, keeping tag FIFO occupancy and outstanding identical.
  assign req_valid_o = !rst_i && !redirect_i && (drop_cnt_q == '0) &&
                       (outstanding < CW'(MAX_OUT)) &&
                       ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
  assign req_pc_o    = fetch_pc_q;
  assign rsp_ready_o = 1'b1;

  assign req_fire = req_valid_o && req_ready_i;
  assign rsp_keep = rsp_valid_i && !redirect_i && (drop_cnt_q == '0);
  assign rsp_drop = rsp_valid_i && !redirect_i && (drop_cnt_q != '0);
  assign deq      = valid_o && ready_i;

  fetch_buffered_fifo #(.W(XLEN), .N(MAX_OUT), .CW(CW)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (req_fire),
    .pop_i   (rsp_keep),
    .dat_i   (fetch_pc_q),
    .head_o  (tag_pc),
    .count_o (outstanding)
  );

  assign enq_dat = '{pc: tag_pc, instr: rsp_instr_i, id: id_q};

  fetch_buffered_fifo #(.W($bits(entry_t)), .N(DEPTH), .CW(CW)) u_iq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (rsp_keep),
    .pop_i   (deq),
    .dat_i   (enq_dat),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    id_d       = id_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      // A response arriving in the redirect cycle is itself one of the stale ones.
      drop_cnt_d = drop_cnt_q + outstanding;
      if (rsp_valid_i && (drop_cnt_d != '0)) drop_cnt_d = drop_cnt_d - CW'(1);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
      if (rsp_keep) id_d = id_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      id_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      id_q       <= id_d;
      assert (!(rsp_keep && (count == CW'(DEPTH)) && !deq))
        else $error("instruction queue overflow");
      assert (!(rsp_keep && (outstanding == '0)))
        else $error("icache response with no request in flight");
    end
  end

  assign valid_o = (count != '0);
  assign pc_o    = valid_o ? head.pc    : '0;
  assign instr_o = valid_o ? head.instr : '0;
  assign id_o    = valid_o ? head.id    : '0;
endmodule

// File: tb/tb_fetch_buffered.sv
// Directed bench for fetch_buffered with a 1-cycle in-order icache model.
module tb_fetch_buffered;
  localparam logic [31:0] K  = 32'h1357_9BDF;   // icache returns instr = pc ^ K
  localparam logic [31:0] RP = 32'h8000_0000;
  localparam logic [31:0] BT = 32'h8000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b1;
  logic [31:0] req_pc_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_instr_i = '0;
  logic        rsp_ready_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] id_o;

  fetch_buffered dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_pc_o      (req_pc_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_instr_i   (rsp_instr_i),
    .rsp_ready_o   (rsp_ready_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .id_o          (id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_chk  = 0;
  bit rsp_en = 1'b1;
  logic [31:0] ic_q[$];      // accepted requests awaiting response
  logic [31:0] req_log[$];
  logic [31:0] dq_pc[$], dq_id[$], dq_instr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  // Low phase: present the icache response, let outputs settle.
  task automatic prep();
    rsp_valid_i = rsp_en && (ic_q.size() > 0);
    rsp_instr_i = rsp_valid_i ? (ic_q[0] ^ K) : 32'h0;
    #1;
  endtask

  // Record handshakes, take the edge, advance the icache model.
  task automatic tick();
    bit f_req, f_rsp;
    logic [31:0] p;
    f_req = req_valid_o && req_ready_i;
    f_rsp = rsp_valid_i;
    p     = req_pc_o;
    if (valid_o && ready_i) begin
      dq_pc.push_back(pc_o);
      dq_id.push_back(id_o);
      dq_instr.push_back(instr_o);
    end
    if (f_req) req_log.push_back(p);
    @(posedge clk_i);
    #1;
    if (f_rsp) void'(ic_q.pop_front());
    if (f_req) ic_q.push_back(p);
    @(negedge clk_i);
  endtask

  task automatic cyc();
    prep();
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    rsp_valid_i = 1'b0;
    ic_q.delete();
    req_log.delete();
    dq_pc.delete();
    dq_id.delete();
    dq_instr.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_rsp_ready", rsp_ready_o, 1);
    chk("rst_pc", pc_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_id", id_o, 0);

    // 1: streaming, one instruction per cycle
    do_reset();
    ready_i = 1; rsp_en = 1;
    prep();
    chk("t1_req_valid0", req_valid_o, 1);
    chk("t1_req_pc0", req_pc_o, RP);
    chk("t1_valid0", valid_o, 0);
    tick();
    repeat (7) cyc();
    chk("t1_nreq", req_log.size(), 8);
    chk("t1_req_pc1", at(req_log, 1), RP + 4);
    chk("t1_req_pc2", at(req_log, 2), RP + 8);
    chk("t1_ndeq", dq_id.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t1_id", at(dq_id, i), i);
      chk("t1_pc", at(dq_pc, i), RP + 32'(4 * i));
      chk("t1_instr", at(dq_instr, i), (RP + 32'(4 * i)) ^ K);
    end

    // 2+5: decode stalls, queue fills to DEPTH, then drains in order at full rate
    do_reset();
    ready_i = 0; rsp_en = 1;
    repeat (9) cyc();
    prep();
    chk("t2_req_valid_full", req_valid_o, 0);
    chk("t2_valid", valid_o, 1);
    chk("t2_head_pc", pc_o, RP);
    chk("t2_head_id", id_o, 0);
    chk("t2_head_instr", instr_o, RP ^ K);
    chk("t2_nreq", req_log.size(), 4);
    tick();
    ready_i = 1;
    prep();
    chk("t2_req_valid_c10", req_valid_o, 0);
    tick();
    repeat (19) cyc();
    chk("t5_ndeq", dq_id.size(), 20);
    for (int i = 0; i < 20; i++) begin
      chk("t5_id", at(dq_id, i), i);
      chk("t5_pc", at(dq_pc, i), RP + 32'(4 * i));
    end

    // 3: redirect with two requests in flight, no response that cycle
    do_reset();
    ready_i = 1; rsp_en = 1;
    cyc(); cyc();
    rsp_en = 0;
    cyc();
    redirect_i = 1; redirect_pc_i = BT;
    prep();
    chk("t3_req_valid_redir", req_valid_o, 0);
    tick();
    redirect_i = 0; rsp_en = 1;
    prep();
    chk("t3_req_valid_drop2", req_valid_o, 0);
    chk("t3_valid_drop2", valid_o, 0);
    tick();
    prep();
    chk("t3_req_valid_drop1", req_valid_o, 0);
    chk("t3_valid_drop1", valid_o, 0);
    tick();
    prep();
    chk("t3_req_valid_tgt", req_valid_o, 1);
    chk("t3_req_pc_tgt", req_pc_o, BT);
    tick();
    cyc();
    prep();
    chk("t3_valid", valid_o, 1);
    chk("t3_pc", pc_o, BT);
    chk("t3_id", id_o, 1);
    chk("t3_instr", instr_o, BT ^ K);
    tick();
    chk("t3_ndeq", dq_id.size(), 2);

    // 4: redirect coinciding with the only outstanding response
    do_reset();
    ready_i = 1; rsp_en = 1;
    cyc();
    redirect_i = 1; redirect_pc_i = BT;
    prep();
    chk("t4_rsp_present", rsp_valid_i, 1);
    tick();
    redirect_i = 0;
    prep();
    chk("t4_req_valid", req_valid_o, 1);
    chk("t4_req_pc", req_pc_o, BT);
    chk("t4_valid", valid_o, 0);
    tick();
    cyc();
    prep();
    chk("t4_valid_tgt", valid_o, 1);
    chk("t4_pc_tgt", pc_o, BT);
    chk("t4_id_tgt", id_o, 0);
    tick();

    // 6: asynchronous reset with work in flight
    do_reset();
    ready_i = 0; rsp_en = 1;
    cyc(); cyc();
    prep();
    chk("t6_pre_valid", valid_o, 1);
    chk("t6_pre_req_valid", req_valid_o, 1);
    rst_i = 1;
    #1;
    chk("t6_async_valid", valid_o, 0);
    chk("t6_async_req_valid", req_valid_o, 0);
    chk("t6_async_pc", pc_o, 0);
    chk("t6_async_id", id_o, 0);
    do_reset();
    ready_i = 1; rsp_en = 1;
    prep();
    chk("t6_req_valid", req_valid_o, 1);
    chk("t6_req_pc", req_pc_o, RP);
    tick();
    cyc();
    prep();
    chk("t6_valid", valid_o, 1);
    chk("t6_pc", pc_o, RP);
    chk("t6_id", id_o, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
